// File: rtl/bf_weight_loader_if.sv
// Byte-stream handshake into the beamformer weight loader.
// A byte transfers on a rising edge where in_valid and in_ready are both high.
interface bf_weight_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bf_weight_loader.sv
// Framed weight loader: assembles 32 five-bit phase weights into a shadow set,
// verifies an XOR checksum, then commits all weights to the outputs in one cycle.
module bf_weight_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [4:0]  COS_RST = 5'b01111,
    parameter logic [4:0]  SIN_RST = 5'b00000
) (
    input  logic                 clock,
    input  logic                 reset,
    bf_weight_loader_if.slave    in_if,
    output logic [7:0][4:0]      w_cos_1,
    output logic [7:0][4:0]      w_sin_1,
    output logic [7:0][4:0]      w_cos_2,
    output logic [7:0][4:0]      w_sin_2,
    output logic                 load_done,
    output logic                 load_err,
    output logic [1:0]           err_code,
    output logic [7:0]           frame_cnt
);
    localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_e;

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [31:0][4:0]  shd_q, shd_d;
    logic [31:0][4:0]  act_q, act_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              hs;

    // Groups 0 and 2 are cos, groups 1 and 3 are sin: bit 3 of the index picks.
    function automatic logic [4:0] rst_w(input int k);
        return k[3] ? SIN_RST : COS_RST;
    endfunction

    assign in_if.in_ready = reset && (state_q != COMMIT);
    assign hs = in_if.in_valid && in_if.in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        tmo_d   = '0;
        shd_d   = shd_q;
        act_d   = act_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        cnt_d   = cnt_q;

        // Idle-gap watchdog; the abort fires on the edge the count reaches TIMEOUT.
        if ((state_q == LOAD || state_q == CHECK) && !hs) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                err_d   = 1'b1;
                code_d  = 2'd2;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (hs && in_if.in_data == HEADER) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    shd_d[idx_q] = in_if.in_data[4:0];
                    acc_d        = acc_q ^ in_if.in_data;
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == 5'd31) state_d = CHECK;
                end
            end
            CHECK: begin
                if (hs) begin
                    if (in_if.in_data == acc_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
            end
            COMMIT: begin
                act_d   = shd_q;
                cnt_d   = cnt_q + 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            tmo_q   <= '0;
            for (int k = 0; k < 32; k++) begin
                shd_q[k] <= rst_w(k);
                act_q[k] <= rst_w(k);
            end
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            tmo_q   <= tmo_d;
            shd_q   <= shd_d;
            act_q   <= act_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_cos_1   = act_q[7:0];
    assign w_sin_1   = act_q[15:8];
    assign w_cos_2   = act_q[23:16];
    assign w_sin_2   = act_q[31:24];
    assign load_done = done_q;
    assign load_err  = err_q;
    assign err_code  = code_q;
    assign frame_cnt = cnt_q;
endmodule

// File: doc/bf_weight_loader.md
Name: bf_weight_loader

Overview:
- Upstream configuration stage for the 8-channel beamformer top.
- Receives a framed byte stream over a valid/ready handshake and assembles the 32 five-bit phase-shift weights (w_cos_1, w_sin_1, w_cos_2, w_sin_2, each with 8 channels) into shadow registers.
- Verifies an XOR checksum, then commits all weights to the active output registers in a single cycle, so the beamformer never sees a partially updated weight set.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame before the frame is aborted (>=2).
- COS_RST, 5'b01111, reset/default value of all w_cos_* outputs (signed +15).
- SIN_RST, 5'b00000, reset/default value of all w_sin_* outputs.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clock.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte transfers on an edge where in_valid & in_ready.
- w_cos_1  out  5 x [7:0]  active cos weights, set 1, channel 0..7.
- w_sin_1  out  5 x [7:0]  active sin weights, set 1.
- w_cos_2  out  5 x [7:0]  active cos weights, set 2.
- w_sin_2  out  5 x [7:0]  active sin weights, set 2.
- load_done  out  1  one-cycle pulse: new weights are visible this cycle.
- load_err  out  1  one-cycle pulse: frame discarded.
- err_code  out  2  last error cause, held until next error/reset: 0 none, 1 checksum, 2 timeout.
- frame_cnt  out  8  count of committed frames, wraps 255 -> 0.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; shadow and active cos regs = COS_RST, sin regs = SIN_RST; in_ready=0 for that cycle; load_done=0, load_err=0, err_code=0, frame_cnt=0, byte index=0, checksum acc=0, timeout ctr=0. Reset mid-frame discards the frame with no error pulse.
- in_ready = 1 in IDLE, LOAD and CHECK; 0 in COMMIT and during reset.
- Frame format: HEADER, 32 weight bytes, 1 checksum byte. Weight byte k (0..31) -> group k/8 (0 w_cos_1, 1 w_sin_1, 2 w_cos_2, 3 w_sin_2), channel k%8. Bits [4:0] are the signed weight; bits [7:5] are ignored for the weight but included in the checksum.
- Checksum: XOR of all 8 bits of the 32 weight bytes. Header is excluded.
- FSM:
  - IDLE: accepted byte == HEADER -> LOAD, index=0, acc=0. Any other accepted byte is dropped silently with no error.
  - LOAD: each accepted byte is written to shadow[index] and acc ^= byte. Index 31 accepted -> CHECK. A HEADER value inside LOAD is treated as data (no resync).
  - CHECK: accepted byte == acc -> COMMIT. Mismatch -> IDLE, load_err=1 the following cycle, err_code=1.
  - COMMIT: one cycle. At its closing edge, all active regs load from shadow simultaneously, frame_cnt++, load_done=1 for the next cycle, state -> IDLE.
- Latency: checksum handshake at edge E0; COMMIT during cycle E0..E1; new weights and load_done visible after E1. Earliest next header is accepted at E2.
- Timeout: in LOAD/CHECK the counter increments each cycle without a handshake and clears on a handshake. When it reaches TIMEOUT -> IDLE, load_err pulse, err_code=2. Active weights are unchanged.
- Active weights change only in COMMIT. A failed or aborted frame leaves them untouched; shadow contents are don't-care.
- load_done and load_err are never high in the same cycle.
- Timeout counter width = clog2(TIMEOUT+1); it saturates and does not wrap.

Test Plan:
- Reset then good frame: A5, bytes k -> k&5'h1F (0..31), checksum = XOR(0..31) = 8'h00 -> after E1 w_cos_1[3]=3, w_sin_2[7]=31; load_done pulses once; frame_cnt=1; err_code=0.
- Bad checksum: same frame with checksum 8'h01 -> load_err pulse, err_code=1, outputs remain COS_RST/SIN_RST, frame_cnt=0.
- Garbage before header (00, FF, 5A, then the good frame) -> garbage ignored, frame commits, no load_err.
- Timeout: A5 plus 10 weight bytes, then in_valid=0 for TIMEOUT cycles -> load_err exactly TIMEOUT cycles after the last handshake, err_code=2. A following good frame commits normally.
- Back-to-back frames with in_valid held high -> in_ready=0 only in each COMMIT cycle, no byte lost, frame_cnt=2. Second frame's values seen only after its own commit.
- Reset mid-frame at byte 20, then a good frame -> no error pulse; outputs reset to defaults; only the second frame commits; frame_cnt=1.
